vga_pixel_fifo: RTL and testbench
=================================

// Module: vga_pixel_fifo
// PURPOSE
// - Pixel source directly upstream of the VGA timing controller; drives its iRed/iGreen/iBlue.
// - Buffers 24-bit RGB pixels from a frame reader over a valid/ready handshake.
// - Releases one pixel per controller request cycle.
// - Aligns the stream to frame start, substitutes a fill colour on underflow and
//   resynchronises on the next frame.
// PARAMETERS
// - DEPTH_LOG2     10          FIFO depth = 2**DEPTH_LOG2 entries (1024)
// - PRIME_LEVEL    512         minimum occupancy required before streaming starts
// - UNDERFLOW_RGB  24'hFF00FF  colour driven when a request finds the FIFO empty
// PORTS
// - iCLK         in   1     pixel clock; same clock as the VGA controller
// - iRST_N       in   1     asynchronous active-low reset
// - iFrameStart  in   1     1-cycle pulse during vertical blank, before the first request of a frame
// - iPixel       in   24    producer pixel {R[23:16],G[15:8],B[7:0]}
// - iSof         in   1     producer marks the first pixel of a frame
// - iValid       in   1     producer data valid
// - oReady       out  1     FIFO accepts data; a transfer occurs when iValid&&oReady
// - iRequest     in   1     controller pixel request (oRequest of the timing block)
// - oRed         out  8     pixel red
// - oGreen       out  8     pixel green
// - oBlue        out  8     pixel blue
// - oLevel       out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
// - oUnderflow   out  1     sticky: a request found the FIFO empty; cleared only by reset
// - oSyncErr     out  1     sticky: iSof popped mid-frame; cleared only by reset
// BEHAVIOUR
// - Reset (async, iRST_N=0):
//   - state=FLUSH, FIFO emptied, oLevel=0.
//   - oRed/oGreen/oBlue=0, oUnderflow=0, oSyncErr=0.
//   - oReady=1 (combinational from FLUSH).
// - Storage: each entry is 25 bits {iSof,iPixel}; circular buffer with DEPTH_LOG2-bit pointers.
//   - Pointers wrap modulo 2**DEPTH_LOG2.
//   - Full and empty are distinguished by the extra oLevel bit.
// - oReady:
//   - FLUSH: 1.
//   - FILL and STREAM: !full.
// - States:
//   - FLUSH:
//     - Incoming pixels are discarded until iValid&&iSof.
//     - That pixel is written; next state is FILL.
//   - FILL:
//     - Pixels are written normally; requests are ignored and outputs are 0.
//     - Go to STREAM on the iFrameStart cycle when oLevel>=PRIME_LEVEL.
//     - An iFrameStart that arrives earlier is ignored; wait for the next one.
//   - STREAM:
//     - Each iRequest cycle pops one entry.
//     - Popped RGB is registered and appears on oRed/oGreen/oBlue on the next cycle
//       (latency 1).
//     - Cycles without a pop drive 0 on the next cycle.
// - Underflow (STREAM, iRequest with the FIFO empty):
//   - Next cycle outputs UNDERFLOW_RGB; oUnderflow<=1.
//   - Next state FLUSH; FIFO emptied.
//   - A push in the same cycle does not bypass and is discarded.
// - Sync check (STREAM):
//   - The first pop after each iFrameStart is expected to carry sof=1.
//   - Any later pop in the same frame that carries sof=1 sets oSyncErr<=1 and outputs
//     UNDERFLOW_RGB; next state FLUSH.
//   - A first pop with sof=0 also sets oSyncErr, with the same recovery.
// - Simultaneous events:
//   - Push and pop in one cycle: oLevel unchanged.
//   - At full, oReady=0, so no push occurs.
//   - iFrameStart together with iRequest: the pop counts as the first pop of the new frame.
// - Arithmetic: oLevel = wr_count - rd_count, saturation-free, width DEPTH_LOG2+1.
// - Reset asserted mid-frame returns to FLUSH immediately.
//   - The producer must restart from a frame boundary; pixels before the next iSof are dropped.
// CONFIGURATION
// - Macro VGA_FIFO_STATS_EN:
//   - Defined: adds output oUnderflowCount[15:0], reset 0.
//     - Increments once per underflow event.
//     - Saturates at 16'hFFFF.
//     - Sync errors are not counted.
//   - Undefined: the port and its counter are absent; all other behaviour is identical.
// TESTING
// - Reset then push 600 pixels (first with iSof), pulse iFrameStart
//   -> STREAM; oLevel=600; request pixel 0 -> RGB = pixel 0 on the next cycle.
// - FILL with 100 pixels, pulse iFrameStart -> stays in FILL.
//   - Reach 512, pulse again -> STREAM.
// - Push 1024 pixels -> oReady=0 at oLevel=1024; push and pop in the same cycle -> oLevel holds.
// - STREAM, drain to empty, assert iRequest
//   -> next cycle RGB=FF/00/FF; oUnderflow=1; FLUSH; oLevel=0.
//   - Non-sof pixels are then dropped.
//   - With VGA_FIFO_STATS_EN: oUnderflowCount=1.
// - Inject iSof on the 5th pixel of a frame -> 5th pop sets oSyncErr=1, RGB=UNDERFLOW_RGB, FLUSH.
// - Drop iRST_N mid-STREAM with oLevel=300 -> outputs 0, oLevel=0, flags 0, oReady=1 asynchronously.

Source files
------------

// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO feeding the VGA timing controller: frame-aligned start, underflow fill colour, resync on error.
// Optional underflow event counter on oUnderflowCount when VGA_FIFO_STATS_EN is defined.
module vga_pixel_fifo #(
    parameter int unsigned DEPTH_LOG2    = 10,
    parameter int unsigned PRIME_LEVEL   = 512,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iFrameStart,
    input  logic [23:0]           iPixel,
    input  logic                  iSof,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic                  iRequest,
    output logic [7:0]            oRed,
    output logic [7:0]            oGreen,
    output logic [7:0]            oBlue,
    output logic [DEPTH_LOG2:0]   oLevel,
    output logic                  oUnderflow,
    output logic                  oSyncErr
`ifdef VGA_FIFO_STATS_EN
    ,
    output logic [15:0]           oUnderflowCount
`endif
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0] cnt_t;
    typedef enum logic [1:0] {FLUSH, FILL, STREAM} state_t;

    localparam cnt_t PRIME_LVL = cnt_t'(PRIME_LEVEL);

    state_t      state_q, state_d;
    cnt_t        wr_cnt_q, wr_cnt_d;
    cnt_t        rd_cnt_q, rd_cnt_d;
    logic [23:0] rgb_q, rgb_d;
    logic        underflow_q, underflow_d;
    logic        sync_err_q, sync_err_d;
    logic        first_pend_q, first_pend_d;
    logic [24:0] mem_q [DEPTH];

    cnt_t        level;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        uf_evt;
    logic        se_evt;
    logic        first_pop;
    logic [24:0] head;

    always_comb begin
        level     = wr_cnt_q - rd_cnt_q;
        empty     = (level == '0);
        full      = level[DEPTH_LOG2];
        head      = mem_q[rd_cnt_q[DEPTH_LOG2-1:0]];
        oReady    = (state_q == FLUSH) ? 1'b1 : !full;

        state_d      = state_q;
        first_pend_d = first_pend_q;
        rgb_d        = '0;
        push         = 1'b0;
        pop          = 1'b0;
        uf_evt       = 1'b0;
        se_evt       = 1'b0;
        first_pop    = first_pend_q || iFrameStart;

        case (state_q)
            FLUSH: begin
                if (iValid && iSof) begin
                    push    = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                push = iValid && !full;
                if (iFrameStart && (level >= PRIME_LVL)) begin
                    state_d      = STREAM;
                    first_pend_d = 1'b1;
                end
            end
            STREAM: begin
                push = iValid && !full;
                if (iFrameStart)
                    first_pend_d = 1'b1;
                if (iRequest) begin
                    if (empty)
                        uf_evt = 1'b1;
                    else if (head[24] != first_pop)
                        se_evt = 1'b1;
                    else begin
                        pop          = 1'b1;
                        rgb_d        = head[23:0];
                        first_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = FLUSH;
        endcase

        wr_cnt_d    = push ? wr_cnt_q + cnt_t'(1) : wr_cnt_q;
        rd_cnt_d    = pop  ? rd_cnt_q + cnt_t'(1) : rd_cnt_q;
        underflow_d = underflow_q || uf_evt;
        sync_err_d  = sync_err_q || se_evt;

        // Either error empties the FIFO and drops any same-cycle push.
        if (uf_evt || se_evt) begin
            push         = 1'b0;
            wr_cnt_d     = '0;
            rd_cnt_d     = '0;
            rgb_d        = UNDERFLOW_RGB;
            state_d      = FLUSH;
            first_pend_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= FLUSH;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            rgb_q        <= '0;
            underflow_q  <= 1'b0;
            sync_err_q   <= 1'b0;
            first_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rgb_q        <= rgb_d;
            underflow_q  <= underflow_d;
            sync_err_q   <= sync_err_d;
            first_pend_q <= first_pend_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push)
            mem_q[wr_cnt_q[DEPTH_LOG2-1:0]] <= {iSof, iPixel};
    end

`ifdef VGA_FIFO_STATS_EN
    logic [15:0] ucount_q, ucount_d;

    always_comb begin
        ucount_d = ucount_q;
        if (uf_evt && (ucount_q != '1))
            ucount_d = ucount_q + 16'd1;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            ucount_q <= '0;
        else
            ucount_q <= ucount_d;
    end

    assign oUnderflowCount = ucount_q;
`endif

    assign oRed       = rgb_q[23:16];
    assign oGreen     = rgb_q[15:8];
    assign oBlue      = rgb_q[7:0];
    assign oLevel     = level;
    assign oUnderflow = underflow_q;
    assign oSyncErr   = sync_err_q;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Bench for vga_pixel_fifo: queue-based frame model checked every cycle plus directed literal checks.
module tb_vga_pixel_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fs = 1'b0;
    logic [23:0] pixel = '0;
    logic        sof = 1'b0;
    logic        valid = 1'b0;
    logic        req = 1'b0;
    logic        ready;
    logic [7:0]  red, green, blue;
    logic [10:0] level;
    logic        uflow, serr;
`ifdef VGA_FIFO_STATS_EN
    logic [15:0] ucount;
`endif

    int tests = 0;
    int fails = 0;

    vga_pixel_fifo #(
        .DEPTH_LOG2(10),
        .PRIME_LEVEL(512),
        .UNDERFLOW_RGB(24'hFF00FF)
    ) dut (
        .iCLK(clk),
        .iRST_N(rst_n),
        .iFrameStart(fs),
        .iPixel(pixel),
        .iSof(sof),
        .iValid(valid),
        .oReady(ready),
        .iRequest(req),
        .oRed(red),
        .oGreen(green),
        .oBlue(blue),
        .oLevel(level),
        .oUnderflow(uflow),
        .oSyncErr(serr)
`ifdef VGA_FIFO_STATS_EN
        ,
        .oUnderflowCount(ucount)
`endif
    );

    always #5 clk = ~clk;

    // Model: a queue of {sof,pixel}, a mode, and the frame's "next pop must be sof" flag.
    typedef enum {M_FLUSH, M_FILL, M_STREAM} mode_t;
    mode_t       m_mode = M_FLUSH;
    logic [24:0] mq[$];
    logic [23:0] m_rgb = '0;
    logic        m_uf = 1'b0;
    logic        m_se = 1'b0;
    logic        m_want_sof = 1'b0;
    int          m_ucnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_mode = M_FLUSH;
            m_rgb = '0;
            m_uf = 1'b0;
            m_se = 1'b0;
            m_want_sof = 1'b0;
            m_ucnt = 0;
        end else begin
            int  n;
            bit  err;
            bit  first;
            n = mq.size();
            err = 0;
            m_rgb = '0;
            case (m_mode)
                M_FLUSH: begin
                    if (valid && sof) begin
                        mq.push_back({sof, pixel});
                        m_mode = M_FILL;
                    end
                end
                M_FILL: begin
                    if (fs && n >= 512) begin
                        m_mode = M_STREAM;
                        m_want_sof = 1'b1;
                    end
                    if (valid && n < 1024) mq.push_back({sof, pixel});
                end
                default: begin
                    if (req) begin
                        first = m_want_sof || fs;
                        if (n == 0) begin
                            err = 1;
                            m_uf = 1'b1;
                            if (m_ucnt < 65535) m_ucnt++;
                        end else if (mq[0][24] != first) begin
                            err = 1;
                            m_se = 1'b1;
                        end else begin
                            m_rgb = mq[0][23:0];
                            void'(mq.pop_front());
                            m_want_sof = 1'b0;
                        end
                    end else if (fs) begin
                        m_want_sof = 1'b1;
                    end
                    if (err) begin
                        mq.delete();
                        m_mode = M_FLUSH;
                        m_rgb = 24'hFF00FF;
                    end else if (valid && n < 1024) begin
                        mq.push_back({sof, pixel});
                    end
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_level", 32'(level), 32'(mq.size()));
        check("cyc_ready", 32'(ready), (m_mode == M_FLUSH || mq.size() < 1024) ? 32'd1 : 32'd0);
        check("cyc_rgb", {8'h0, red, green, blue}, {8'h0, m_rgb});
        check("cyc_uflow", 32'(uflow), 32'(m_uf));
        check("cyc_syncerr", 32'(serr), 32'(m_se));
`ifdef VGA_FIFO_STATS_EN
        check("cyc_ucount", 32'(ucount), 32'(m_ucnt));
`endif
    end

    function automatic logic [23:0] pix(input int i);
        logic [31:0] w;
        w = i;
        return {w[7:0] ^ 8'h3C, w[15:8] + 8'h11, 8'(w * 7)};
    endfunction

    task automatic step(input logic v_, input logic s_, input logic [23:0] p_,
                        input logic r_, input logic f_);
        valid = v_;
        sof   = s_;
        pixel = p_;
        req   = r_;
        fs    = f_;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", 32'(level), 0);
        check("rst_ready", 32'(ready), 1);
        check("rst_rgb", {8'h0, red, green, blue}, 0);
        rst_n = 1'b1;
        step(0, 0, '0, 0, 0);

        // Prime with 600 pixels, start the frame, pop pixel 0.
        for (int i = 0; i < 600; i++) step(1, i == 0, pix(i), 0, 0);
        check("a_level600", 32'(level), 600);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 1, 0);
        check("a_rgb_pix0", {8'h0, red, green, blue}, {8'h0, pix(0)});
        check("a_level599", 32'(level), 599);

        // Fill to full; extra pushes are refused.
        for (int i = 600; i < 1030; i++) step(1, 0, pix(i), 0, 0);
        check("c_level_full", 32'(level), 1024);
        check("c_ready_full", 32'(ready), 0);
        step(0, 0, '0, 1, 0);
        check("c_pop_pix1", {8'h0, red, green, blue}, {8'h0, pix(1)});
        step(1, 0, pix(2000), 1, 0);
        check("c_pushpop_level", 32'(level), 1023);

        // Drain, then one request too many.
        for (int i = 0; i < 1023; i++) step(0, 0, '0, 1, 0);
        check("d_last_pix", {8'h0, red, green, blue}, {8'h0, pix(2000)});
        check("d_empty", 32'(level), 0);
        step(1, 0, pix(2001), 1, 0);
        check("d_uf_rgb", {8'h0, red, green, blue}, 32'h00FF00FF);
        check("d_uf_flag", 32'(uflow), 1);
        check("d_uf_level", 32'(level), 0);
        check("d_uf_ready", 32'(ready), 1);
`ifdef VGA_FIFO_STATS_EN
        check("d_ucount", 32'(ucount), 1);
`endif
        for (int i = 0; i < 5; i++) step(1, 0, pix(2100 + i), 0, 0);
        check("d_flush_drop", 32'(level), 0);

        // Early frame start stays in FILL; sof injected on 5th pixel.
        for (int i = 0; i < 100; i++) step(1, i == 0 || i == 4, pix(3000 + i), 0, 0);
        check("b_level100", 32'(level), 100);
        step(0, 0, '0, 1, 1);
        check("b_fill_rgb0", {8'h0, red, green, blue}, 0);
        check("b_fill_level", 32'(level), 100);
        for (int i = 100; i < 512; i++) step(1, 0, pix(3000 + i), 0, 0);
        check("b_level512", 32'(level), 512);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 1, 0);
        check("b_first_pop", {8'h0, red, green, blue}, {8'h0, pix(3000)});
        for (int k = 1; k < 4; k++) step(0, 0, '0, 1, 0);
        check("b_fourth_pop", {8'h0, red, green, blue}, {8'h0, pix(3003)});
        check("b_no_serr", 32'(serr), 0);
        step(0, 0, '0, 1, 0);
        check("e_serr", 32'(serr), 1);
        check("e_serr_rgb", {8'h0, red, green, blue}, 32'h00FF00FF);
        check("e_serr_level", 32'(level), 0);

        // Stream down to 300 then hit reset mid-cycle.
        for (int i = 0; i < 600; i++) step(1, i == 0, pix(5000 + i), 0, 0);
        step(0, 0, '0, 0, 1);
        for (int i = 0; i < 300; i++) step(0, 0, '0, 1, 0);
        check("r_level300", 32'(level), 300);
        #1;
        rst_n = 1'b0;
        #1;
        check("r_async_level", 32'(level), 0);
        check("r_async_rgb", {8'h0, red, green, blue}, 0);
        check("r_async_uf", 32'(uflow), 0);
        check("r_async_serr", 32'(serr), 0);
        check("r_async_ready", 32'(ready), 1);
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, '0, 0, 0);
        step(1, 0, pix(9), 0, 0);
        check("r_post_drop", 32'(level), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
